// File: rtl/spi_driver_if.sv
// rtl/spi_driver_if.sv - request/sample and ADC pin bundle for spi_driver
//
// Purpose: groups the CPU-side request/result signals and the external ADC
// pins driven or sampled by spi_driver.
// Signals:
//   getV    conversion request (CPU -> driver)
//   vReady  v holds a completed sample (driver -> CPU)
//   v[9:0]  last converted sample (driver -> CPU)
//   CS      ADC chip select, active low (driver -> ADC)
//   MOSI    command bits (driver -> ADC)
//   MISO    data bits (ADC -> driver)
// Modports: master = the driver side, slave = CPU logic plus ADC pins.

interface spi_driver_if;
  logic       getV;
  logic       vReady;
  logic [9:0] v;
  logic       CS;
  logic       MOSI;
  logic       MISO;

  modport master (
    input  getV,
    input  MISO,
    output vReady,
    output v,
    output CS,
    output MOSI
  );

  modport slave (
    output getV,
    output MISO,
    input  vReady,
    input  v,
    input  CS,
    input  MOSI
  );
endinterface

// File: rtl/spi_driver.sv
// rtl/spi_driver.sv - SPI master front end for a 10-bit MCP3008-style ADC
//
// Purpose: on getV, runs one ADC frame: CS low, start bit + SGL/DIFF +
// 3 channel bits on MOSI, one discarded null bit, then 10 data bits read
// MSB-first from MISO into v, with vReady raised as a level.
// Parameters:
//   CHANNEL       ADC input channel sent as D2..D0
//   SINGLE_ENDED  SGL/DIFF command bit (1 = single-ended)
// Ports:
//   SCLK  sole clock, rising edge; also forwarded to the ADC as serial clock
//   RST   asynchronous active-high reset
//   bus   spi_driver_if.master (getV, vReady, v, CS, MOSI, MISO)

module spi_driver #(
  parameter logic [2:0] CHANNEL      = 3'd0,
  parameter logic       SINGLE_ENDED = 1'b1
) (
  input  logic            SCLK,
  input  logic            RST,
  spi_driver_if.master    bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    NULL = 3'd2,
    READ = 3'd3,
    DONE = 3'd4
  } state_t;

  // Command bits following the start bit, sent first to last by cnt 0..3.
  localparam logic [3:0] CMD_BITS = {SINGLE_ENDED, CHANNEL};

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [9:0] shift, shift_n;
  logic       cs_q, cs_n;
  logic       mosi_q, mosi_n;
  logic       vready_q, vready_n;
  logic [9:0] v_q, v_n;

  // State and registered outputs; every pin is driven straight from a flop.
  always_ff @(posedge SCLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      shift    <= 10'd0;
      cs_q     <= 1'b1;
      mosi_q   <= 1'b0;
      vready_q <= 1'b0;
      v_q      <= 10'd0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      shift    <= shift_n;
      cs_q     <= cs_n;
      mosi_q   <= mosi_n;
      vready_q <= vready_n;
      v_q      <= v_n;
    end
  end

  // Next state and bit counter. cnt counts edges within CMD, NULL and READ.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        cnt_n = 4'd0;
        if (bus.getV) state_n = CMD;
      end
      CMD: begin
        if (cnt == 4'd3) begin
          state_n = NULL;
          cnt_n   = 4'd0;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      NULL: begin
        if (cnt == 4'd1) begin
          state_n = READ;
          cnt_n   = 4'd0;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      READ: begin
        if (cnt == 4'd9) begin
          state_n = DONE;
          cnt_n   = 4'd0;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  // Next values of the registered outputs and the shift register.
  always_comb begin
    cs_n     = cs_q;
    mosi_n   = mosi_q;
    vready_n = vready_q;
    v_n      = v_q;
    shift_n  = shift;
    unique case (state)
      IDLE: begin
        cs_n   = 1'b1;
        mosi_n = 1'b0;
        if (bus.getV) begin
          cs_n     = 1'b0;
          mosi_n   = 1'b1;   // start bit
          vready_n = 1'b0;
          shift_n  = 10'd0;
        end
      end
      CMD: begin
        mosi_n = CMD_BITS[2'd3 - cnt[1:0]];
      end
      NULL: begin
        // First edge drives MOSI low; second edge passes the null bit by.
        mosi_n = 1'b0;
      end
      READ: begin
        mosi_n  = 1'b0;
        shift_n = (shift << 1) | {9'd0, bus.MISO};
        if (cnt == 4'd9) begin
          v_n      = shift_n;
          vready_n = 1'b1;
          cs_n     = 1'b1;
        end
      end
      DONE: begin
        // Second CS-high edge before IDLE may start another frame.
        cs_n   = 1'b1;
        mosi_n = 1'b0;
      end
      default: begin
        cs_n   = 1'b1;
        mosi_n = 1'b0;
      end
    endcase
  end

  assign bus.CS     = cs_q;
  assign bus.MOSI   = mosi_q;
  assign bus.vReady = vready_q;
  assign bus.v      = v_q;

endmodule

// File: tb/tb_spi_driver.sv
// tb/tb_spi_driver.sv - self-checking bench for spi_driver against a frame model

module tb_spi_driver;

  localparam logic [2:0] CH  = 3'd5;
  localparam logic       SGL = 1'b1;

  logic SCLK = 1'b0;
  logic RST  = 1'b0;

  spi_driver_if bus ();

  spi_driver #(
    .CHANNEL      (CH),
    .SINGLE_ENDED (SGL)
  ) dut (
    .SCLK (SCLK),
    .RST  (RST),
    .bus  (bus)
  );

  always #5 SCLK = ~SCLK;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [9:0] exp_v    = 10'd0;
  logic       exp_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame model: MOSI after edge Ek carries start, SGL, D2, D1, D0, then 0.
  function automatic logic exp_mosi(input int k);
    case (k)
      0:       return 1'b1;
      1:       return SGL;
      2:       return CH[2];
      3:       return CH[1];
      4:       return CH[0];
      default: return 1'b0;
    endcase
  endfunction

  // One frame of 18 edges (E0..E17). gmode: 0 getV held, 1 one-edge pulse,
  // 2 random after E0. abort_at >= 0 asserts RST just after that edge.
  task automatic run_frame(input logic [9:0] data, input int gmode, input int abort_at);
    for (int k = 0; k < 18; k++) begin
      @(negedge SCLK);
      if (k == 0)          bus.getV = 1'b1;
      else if (gmode == 0) bus.getV = 1'b1;
      else if (gmode == 1) bus.getV = 1'b0;
      else                 bus.getV = 1'($urandom_range(0, 1));
      if (k >= 7 && k <= 16) bus.MISO = data[16 - k];
      else                   bus.MISO = 1'($urandom_range(0, 1));
      @(posedge SCLK);
      #1;
      if (k == abort_at) begin
        #1 RST = 1'b1;
        #1;
        exp_v     = 10'd0;
        exp_ready = 1'b0;
        check($sformatf("abort_cs_e%0d", k), bus.CS, 1'b1);
        check($sformatf("abort_mosi_e%0d", k), bus.MOSI, 1'b0);
        check($sformatf("abort_vready_e%0d", k), bus.vReady, 1'b0);
        check($sformatf("abort_v_e%0d", k), bus.v, 10'd0);
        #1 RST = 1'b0;
        return;
      end
      if (k == 0)  exp_ready = 1'b0;
      if (k == 16) begin
        exp_v     = data;
        exp_ready = 1'b1;
      end
      check($sformatf("cs_e%0d", k), bus.CS, (k >= 16) ? 1'b1 : 1'b0);
      check($sformatf("mosi_e%0d", k), bus.MOSI, exp_mosi(k));
      check($sformatf("vready_e%0d", k), bus.vReady, exp_ready);
      check($sformatf("v_e%0d", k), bus.v, exp_v);
    end
  endtask

  // Idle edges with getV low: no frame may start, results must hold.
  task automatic idle_edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge SCLK);
      bus.getV = 1'b0;
      bus.MISO = 1'($urandom_range(0, 1));
      @(posedge SCLK);
      #1;
      check("idle_cs", bus.CS, 1'b1);
      check("idle_mosi", bus.MOSI, 1'b0);
      check("idle_vready", bus.vReady, exp_ready);
      check("idle_v", bus.v, exp_v);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.getV = 1'b0;
    bus.MISO = 1'b0;
    #1 RST = 1'b1;
    #2;
    check("rst_cs", bus.CS, 1'b1);
    check("rst_mosi", bus.MOSI, 1'b0);
    check("rst_vready", bus.vReady, 1'b0);
    check("rst_v", bus.v, 10'd0);
    @(posedge SCLK);
    #1 RST = 1'b0;

    // Single conversion with all-ones data, getV pulsed for one edge.
    run_frame(10'h3FF, 1, -1);
    idle_edges(3);

    // Known data pattern for bit order.
    run_frame(10'b1011001110, 1, -1);
    idle_edges(2);

    // getV held: back-to-back frames every 18 edges.
    for (int f = 0; f < 4; f++) run_frame(10'($urandom), 0, -1);
    idle_edges(2);

    // getV wiggling after E0 must not disturb the frame.
    for (int f = 0; f < 6; f++) begin
      run_frame(10'($urandom), 2, -1);
      idle_edges(int'($urandom_range(1, 3)));
    end

    // Reset during the read phase, then a clean frame straight after.
    run_frame(10'($urandom), 0, 10);
    run_frame(10'($urandom), 1, -1);
    idle_edges(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
